// File: rtl/hazard_pkg.sv
// Shared constants for the decode-stage hazard scoreboard.
package hazard_pkg;

  localparam int unsigned TW_DEF  = 2;
  localparam int unsigned EPC_IDX = 14;

  localparam int unsigned NCAUSE     = 4;
  localparam int unsigned CAUSE_RS   = 0;
  localparam int unsigned CAUSE_RT   = 1;
  localparam int unsigned CAUSE_MD   = 2;
  localparam int unsigned CAUSE_ERET = 3;

  // Tuse encoding meaning "operand not read": all ones at the given width.
  function automatic logic [31:0] tuse_unused(input int unsigned tw);
    return (32'd1 << tw) - 32'd1;
  endfunction

endpackage

// File: rtl/sat_down_counter.sv
// Loadable down-counter that saturates at zero; flush clears it.
module sat_down_counter #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         flush,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] value
);

  always_ff @(posedge clk) begin
    if (reset) begin
      value <= '0;
    end else if (flush) begin
      value <= '0;
    end else if (load) begin
      value <= load_val;
    end else if (value != '0) begin
      value <= value - W'(1);
    end
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// Decode-stage stall generator using per-register Tnew countdowns.
// Optional HI/LO busy tracking is built only when HAZARD_MD_EN is defined.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int unsigned NREG     = 32,
  parameter int unsigned NSRC     = 2,
  parameter int unsigned TW       = hazard_pkg::TW_DEF,
  parameter int unsigned MULT_LAT = 5,
  parameter int unsigned DIV_LAT  = 10,
  parameter int unsigned EPC_IDX  = hazard_pkg::EPC_IDX,
  localparam int unsigned AW      = $clog2(NREG)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               flush,
  input  logic               d_valid,
  input  logic [NSRC*AW-1:0] d_src,
  input  logic [NSRC*TW-1:0] d_tuse,
  input  logic               d_we,
  input  logic [AW-1:0]      d_dst,
  input  logic [TW-1:0]      d_tnew,
  input  logic               d_md,
  input  logic               d_div,
  input  logic               d_hilo,
  input  logic               d_mtc0,
  input  logic [4:0]         d_cp0,
  input  logic               d_eret,
  output logic               stall,
  output logic [3:0]         stall_cause,
  output logic               md_busy
);

  logic [TW-1:0]   cnt [NREG];
  logic            issue;
  logic [NSRC-1:0] src_hit;
  logic            rt_hit;
  logic            md_hit;
  logic            eret_hit;
  logic [AW-1:0]   src_k;
  logic [TW-1:0]   tuse_k;
  logic [1:0]      epc_cnt;
  logic            epc_load;

  assign issue = d_valid & ~stall & ~flush;

  // Register 0 never holds a pending write; other entries count Tnew down.
  for (genvar r = 0; r < NREG; r++) begin : g_sb
    if (r == 0) begin : g_zero
      assign cnt[r] = '0;
    end else begin : g_ent
      logic [TW-1:0] q;
      always_ff @(posedge clk) begin
        if (reset) begin
          q <= '0;
        end else if (flush) begin
          q <= '0;
        end else if (issue && d_we && (d_dst == AW'(r))) begin
          q <= d_tnew;
        end else if (q != '0) begin
          q <= q - TW'(1);
        end
      end
      assign cnt[r] = q;
    end
  end

  // Per-slot data hazard against the pre-issue scoreboard.
  always_comb begin
    src_hit = '0;
    rt_hit  = 1'b0;
    src_k   = '0;
    tuse_k  = '0;
    for (int k = 0; k < NSRC; k++) begin
      src_k  = d_src[k*AW +: AW];
      tuse_k = d_tuse[k*TW +: TW];
      src_hit[k] = (src_k != '0) && (32'(tuse_k) != tuse_unused(TW)) &&
                   (cnt[src_k] > tuse_k);
    end
    for (int k = 1; k < NSRC; k++) begin
      rt_hit = rt_hit | src_hit[k];
    end
  end

`ifdef HAZARD_MD_EN
  localparam int unsigned MD_MAX = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
  localparam int unsigned MDW    = $clog2(MD_MAX + 1);

  logic [MDW-1:0] md_cnt;
  logic           md_load;

  assign md_load = issue & d_md;

  // A started mult/div always completes, so flush does not touch it.
  sat_down_counter #(.W(MDW)) u_md_cnt (
    .clk      (clk),
    .reset    (reset),
    .flush    (1'b0),
    .load     (md_load),
    .load_val (d_div ? MDW'(DIV_LAT) : MDW'(MULT_LAT)),
    .value    (md_cnt)
  );

  assign md_busy = (md_cnt != '0);
  assign md_hit  = d_hilo & md_busy;
`else
  logic unused_md;
  assign unused_md = ^{d_md, d_div, d_hilo, 32'(MULT_LAT), 32'(DIV_LAT)};
  assign md_busy   = 1'b0;
  assign md_hit    = 1'b0;
`endif

  assign epc_load = issue & d_mtc0 & (d_cp0 == 5'(EPC_IDX));

  sat_down_counter #(.W(2)) u_epc_cnt (
    .clk      (clk),
    .reset    (reset),
    .flush    (flush),
    .load     (epc_load),
    .load_val (2'd2),
    .value    (epc_cnt)
  );

  assign eret_hit = d_eret & (epc_cnt != '0);

  always_comb begin
    stall_cause             = '0;
    stall_cause[CAUSE_RS]   = d_valid & src_hit[0];
    stall_cause[CAUSE_RT]   = d_valid & rt_hit;
    stall_cause[CAUSE_MD]   = d_valid & md_hit;
    stall_cause[CAUSE_ERET] = d_valid & eret_hit;
  end

  assign stall = |stall_cause;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: directed vector table, reset corner and
// randomized traffic against a per-register countdown model.
module tb_hazard_scoreboard;

`ifdef HAZARD_MD_EN
  localparam bit MD_EN = 1'b1;
`else
  localparam bit MD_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  logic        d_valid;
  logic [9:0]  d_src;
  logic [3:0]  d_tuse;
  logic        d_we;
  logic [4:0]  d_dst;
  logic [1:0]  d_tnew;
  logic        d_md;
  logic        d_div;
  logic        d_hilo;
  logic        d_mtc0;
  logic [4:0]  d_cp0;
  logic        d_eret;
  logic        stall;
  logic [3:0]  stall_cause;
  logic        md_busy;

  hazard_scoreboard dut (
    .clk         (clk),
    .reset       (reset),
    .flush       (flush),
    .d_valid     (d_valid),
    .d_src       (d_src),
    .d_tuse      (d_tuse),
    .d_we        (d_we),
    .d_dst       (d_dst),
    .d_tnew      (d_tnew),
    .d_md        (d_md),
    .d_div       (d_div),
    .d_hilo      (d_hilo),
    .d_mtc0      (d_mtc0),
    .d_cp0       (d_cp0),
    .d_eret      (d_eret),
    .stall       (stall),
    .stall_cause (stall_cause),
    .md_busy     (md_busy)
  );

  always #5 clk = ~clk;

  // kind: 0 plain, 1 div, 2 mult, 3 mflo, 4 mtc0 EPC, 5 mtc0 SR, 6 eret
  typedef struct {
    bit       valid;
    bit [4:0] s0;
    bit [1:0] t0;
    bit [4:0] s1;
    bit [1:0] t1;
    bit       we;
    bit [4:0] dst;
    bit [1:0] tnew;
    int       kind;
    bit       fl;
    bit       es;
    bit [3:0] ec;
  } vec_t;

  int checks = 0;
  int errors = 0;

  int       sb [32];
  int       md_left;
  int       epc_left;
  bit       m_stall;
  bit [3:0] m_cause;

  vec_t tbl [$];

  function automatic vec_t mk(bit valid, bit [4:0] s0, bit [1:0] t0,
                              bit [4:0] s1, bit [1:0] t1, bit we,
                              bit [4:0] dst, bit [1:0] tnew, int kind,
                              bit fl, bit es, bit [3:0] ec);
    vec_t v;
    v.valid = valid; v.s0 = s0; v.t0 = t0; v.s1 = s1; v.t1 = t1;
    v.we = we; v.dst = dst; v.tnew = tnew; v.kind = kind; v.fl = fl;
    v.es = es; v.ec = ec;
    return v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic apply(input vec_t v);
    d_valid = v.valid;
    d_src   = {v.s1, v.s0};
    d_tuse  = {v.t1, v.t0};
    d_we    = v.we;
    d_dst   = v.dst;
    d_tnew  = v.tnew;
    d_md    = (v.kind == 1) || (v.kind == 2);
    d_div   = (v.kind == 1);
    d_hilo  = (v.kind >= 1) && (v.kind <= 3);
    d_mtc0  = (v.kind == 4) || (v.kind == 5);
    d_cp0   = (v.kind == 4) ? 5'd14 : ((v.kind == 5) ? 5'd12 : 5'd0);
    d_eret  = (v.kind == 6);
    flush   = v.fl;
  endtask

  // Reference: stall whenever a source's remaining Tnew exceeds its Tuse.
  function automatic void model_eval();
    bit rs_h, rt_h, md_h, er_h;
    int src, tu;
    rs_h = 0; rt_h = 0;
    for (int k = 0; k < 2; k++) begin
      src = int'(d_src[k*5 +: 5]);
      tu  = int'(d_tuse[k*2 +: 2]);
      if (src != 0 && tu != 3 && sb[src] > tu) begin
        if (k == 0) rs_h = 1; else rt_h = 1;
      end
    end
    md_h = MD_EN && d_hilo && (md_left > 0);
    er_h = d_eret && (epc_left > 0);
    m_cause = d_valid ? {er_h, md_h, rt_h, rs_h} : 4'b0000;
    m_stall = (m_cause != 4'b0000);
  endfunction

  function automatic void model_update();
    bit iss;
    if (reset) begin
      foreach (sb[r]) sb[r] = 0;
      md_left = 0;
      epc_left = 0;
      return;
    end
    iss = d_valid && !m_stall && !flush;
    for (int r = 1; r < 32; r++) begin
      if (flush) sb[r] = 0;
      else if (iss && d_we && int'(d_dst) == r) sb[r] = int'(d_tnew);
      else if (sb[r] > 0) sb[r]--;
    end
    if (MD_EN) begin
      if (iss && d_md) md_left = d_div ? 10 : 5;
      else if (md_left > 0) md_left--;
    end
    if (flush) epc_left = 0;
    else if (iss && d_mtc0 && d_cp0 == 5'd14) epc_left = 2;
    else if (epc_left > 0) epc_left--;
  endfunction

  // Compare against the model, then advance one clock.
  task automatic step(input string tag);
    #1;
    model_eval();
    chk({tag, ".stall"}, int'(stall), int'(m_stall));
    chk({tag, ".cause"}, int'(stall_cause), int'(m_cause));
    chk({tag, ".md_busy"}, int'(md_busy), int'(MD_EN && md_left > 0));
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  vec_t idle;

  initial begin
    idle = mk(0, 0,3, 0,3, 0,0,0, 0, 0, 0, 4'b0000);
    foreach (sb[r]) sb[r] = 0;
    md_left = 0;
    epc_left = 0;
    reset = 1'b1;
    apply(idle);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Reset state, with an instruction that would hazard if any count survived.
    apply(mk(1, 8,0, 9,0, 0,0,0, 6, 0, 0, 4'b0000));
    #1;
    chk("reset.stall", int'(stall), 0);
    chk("reset.cause", int'(stall_cause), 0);
    chk("reset.md_busy", int'(md_busy), 0);
    @(negedge clk);

    // load r8 then add r8 (Tuse 1)
    tbl.push_back(mk(1, 0,3, 0,3, 1,8,2, 0, 0, 0, 4'b0000));
    tbl.push_back(mk(1, 8,1, 9,1, 1,10,1, 0, 0, 1, 4'b0001));
    tbl.push_back(mk(1, 8,1, 9,1, 1,10,1, 0, 0, 0, 4'b0000));
    tbl.push_back(idle);
    // load r8 then beq r8 (Tuse 0), then store rt=r8 (Tuse 2)
    tbl.push_back(mk(1, 0,3, 0,3, 1,8,2, 0, 0, 0, 4'b0000));
    tbl.push_back(mk(1, 8,0, 0,0, 0,0,0, 0, 0, 1, 4'b0001));
    tbl.push_back(mk(1, 8,0, 0,0, 0,0,0, 0, 0, 1, 4'b0001));
    tbl.push_back(mk(1, 8,0, 0,0, 0,0,0, 0, 0, 0, 4'b0000));
    tbl.push_back(mk(1, 0,3, 0,3, 1,8,2, 0, 0, 0, 4'b0000));
    tbl.push_back(mk(1, 29,1, 8,2, 0,0,0, 0, 0, 0, 4'b0000));
    tbl.push_back(mk(1, 0,3, 8,0, 0,0,0, 0, 0, 1, 4'b0010));
    tbl.push_back(mk(1, 0,3, 8,0, 0,0,0, 0, 0, 0, 4'b0000));
    // writer to r0 never creates a hazard
    tbl.push_back(mk(1, 0,3, 0,3, 1,0,2, 0, 0, 0, 4'b0000));
    tbl.push_back(mk(1, 0,0, 0,3, 0,0,0, 0, 0, 0, 4'b0000));
    tbl.push_back(mk(1, 0,3, 0,0, 0,0,0, 0, 0, 0, 4'b0000));
    // div then mflo
    tbl.push_back(mk(1, 0,3, 0,3, 0,0,0, 1, 0, 0, 4'b0000));
    for (int i = 0; i < 10; i++)
      tbl.push_back(mk(1, 0,3, 0,3, 1,3,1, 3, 0, MD_EN, MD_EN ? 4'b0100 : 4'b0000));
    tbl.push_back(mk(1, 0,3, 0,3, 1,3,1, 3, 0, 0, 4'b0000));
    tbl.push_back(idle);
    // mtc0 EPC then eret; mtc0 SR then eret
    tbl.push_back(mk(1, 5,1, 0,3, 0,0,0, 4, 0, 0, 4'b0000));
    tbl.push_back(mk(1, 0,3, 0,3, 0,0,0, 6, 0, 1, 4'b1000));
    tbl.push_back(mk(1, 0,3, 0,3, 0,0,0, 6, 0, 1, 4'b1000));
    tbl.push_back(mk(1, 0,3, 0,3, 0,0,0, 6, 0, 0, 4'b0000));
    tbl.push_back(mk(1, 5,1, 0,3, 0,0,0, 5, 0, 0, 4'b0000));
    tbl.push_back(mk(1, 0,3, 0,3, 0,0,0, 6, 0, 0, 4'b0000));
    // load r9, flush, reader of r9
    tbl.push_back(mk(1, 0,3, 0,3, 1,9,2, 0, 0, 0, 4'b0000));
    tbl.push_back(mk(0, 0,3, 0,3, 0,0,0, 0, 1, 0, 4'b0000));
    tbl.push_back(mk(1, 9,0, 9,0, 0,0,0, 0, 0, 0, 4'b0000));
    // source equals own destination: checked before the write lands
    tbl.push_back(mk(1, 5,0, 0,3, 1,5,2, 0, 0, 0, 4'b0000));
    tbl.push_back(mk(1, 5,0, 0,3, 1,5,2, 0, 0, 1, 4'b0001));
    tbl.push_back(mk(1, 5,0, 0,3, 1,5,2, 0, 0, 1, 4'b0001));
    tbl.push_back(mk(1, 5,0, 0,3, 1,5,2, 0, 0, 0, 4'b0000));
    // d_valid gates the hazard
    tbl.push_back(mk(0, 5,0, 5,0, 0,0,0, 6, 0, 0, 4'b0000));
    tbl.push_back(mk(1, 5,0, 0,3, 0,0,0, 0, 0, 1, 4'b0001));
    tbl.push_back(idle);

    foreach (tbl[i]) begin
      apply(tbl[i]);
      #1;
      chk($sformatf("vec%0d.stall", i), int'(stall), int'(tbl[i].es));
      chk($sformatf("vec%0d.cause", i), int'(stall_cause), int'(tbl[i].ec));
      step($sformatf("vec%0d.model", i));
    end

    // Reset mid-operation drops a running divide and a same-cycle issue.
    apply(mk(1, 0,3, 0,3, 0,0,0, 1, 0, 0, 4'b0000));
    step("rst.div");
    apply(idle);
    for (int i = 0; i < 3; i++) step("rst.idle");
    #1;
    chk("rst.md_busy_pre", int'(md_busy), int'(MD_EN));
    reset = 1'b1;
    apply(mk(1, 0,3, 0,3, 1,8,2, 0, 0, 0, 4'b0000));
    step("rst.assert");
    reset = 1'b0;
    apply(mk(1, 8,0, 0,3, 0,0,0, 3, 0, 0, 4'b0000));
    #1;
    chk("rst.md_busy_post", int'(md_busy), 0);
    chk("rst.stall_post", int'(stall), 0);
    step("rst.after");

    // Randomized traffic on a small register window to provoke hazards.
    for (int i = 0; i < 3000; i++) begin
      vec_t v;
      int kr;
      kr = int'($urandom_range(0, 14));
      v = mk($urandom_range(0, 9) != 0,
             5'($urandom_range(0, 7)), 2'($urandom_range(0, 3)),
             5'($urandom_range(0, 7)), 2'($urandom_range(0, 3)),
             1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
             2'($urandom_range(0, 2)), (kr > 6) ? 0 : kr,
             $urandom_range(0, 19) == 0, 0, 4'b0000);
      reset = ($urandom_range(0, 199) == 0);
      apply(v);
      step("rand");
    end
    reset = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
